lfsr_stage: RTL and testbench
=============================

LFSR_STAGE -- requirements
Module: lfsr_stage

Interface
REQ-001 Parameter WIDTH, default 22, register length in bits (min 4).
REQ-002 Parameter TAP_MASK, default 22'h300000, feedback taps; bit i set means reg[i] enters the feedback XOR.
REQ-003 Parameter CLK_BIT, default 10, index of the majority/clocking bit.
REQ-004 Parameter KEY_BITS, default 64, serial key bits per init.
REQ-005 Parameter FRAME_BITS, default 22, serial frame bits per init.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle pulse; begins serial initialisation.
REQ-009 bit_valid  in  1  serial init bit present on bit_in.
REQ-010 bit_in  in  1  serial key/frame bit.
REQ-011 bit_ready  out  1  block accepts a serial bit this cycle.
REQ-012 trigger  in  1  step enable in RUN phase.
REQ-013 load  in  1  parallel load strobe.
REQ-014 key  in  WIDTH  parallel load value.
REQ-015 out_reg  out  1  reg[WIDTH-1], keystream contribution.
REQ-016 maj_bit  out  1  reg[CLK_BIT], majority-vote input.
REQ-017 state_q  out  WIDTH  full register contents.
REQ-018 phase  out  2  00 IDLE, 01 KEY, 10 FRAME, 11 RUN.
REQ-019 init_done  out  1  one-cycle pulse on entering RUN from FRAME.
REQ-020 zero_state  out  1  high while reg == 0 (lock-up indication).

Function
REQ-021 Feedback fb SHALL be XOR of reg bits selected by TAP_MASK; step SHALL set reg <= {reg[WIDTH-2:0], fb ^ inj}.
REQ-022 inj SHALL be bit_in during an accepted serial bit, 0 otherwise.
REQ-023 Priority each cycle: load > start > serial step > trigger step.
REQ-024 load SHALL set reg <= key and phase <= RUN in any phase, counter cleared, no init_done pulse.
REQ-025 start (without load) SHALL clear reg to 0, clear counter, phase <= KEY, in any phase (restart mid-init allowed).
REQ-026 bit_ready SHALL equal 1 exactly when phase is KEY or FRAME; comb, no dependence on bit_valid.
REQ-027 Accepted bit = bit_valid & bit_ready; each SHALL perform one step with inj = bit_in and increment counter; no step when bit_valid low (stall).
REQ-028 After accepting bit KEY_BITS in KEY: phase <= FRAME, counter <= 0 same edge.
REQ-029 After accepting bit FRAME_BITS in FRAME: phase <= RUN, counter <= 0, init_done = 1 the following cycle only.
REQ-030 In RUN, trigger=1 SHALL step with inj=0; trigger SHALL be ignored in IDLE, KEY, FRAME.
REQ-031 Mixing/majority clocking SHALL be done externally via trigger; no internal mixing cycles.
REQ-032 Counter width $clog2(max(KEY_BITS,FRAME_BITS)+1); no wrap beyond terminal count.
REQ-033 out_reg, maj_bit, state_q, zero_state SHALL be combinational from reg, zero added latency.

Reset
REQ-034 rst_n=0 at an edge SHALL force reg=0, counter=0, phase=IDLE, init_done=0, overriding load/start.
REQ-035 After reset: out_reg=0, maj_bit=0, state_q=0, bit_ready=0, zero_state=1.

Structure
REQ-036 Phase encoding constants and default A5/1 tap masks (19/22/23-bit: 0x72000, 0x300000, 0x700080) SHALL live in shared package a51_pkg.
REQ-037 Single module; counter and phase FSM inline; no sub-module required.
REQ-038 Three instances with WIDTH 19/22/23 SHALL replace the fixed-width registers.

Verification
REQ-039 Reset held 2 cycles -> state_q=0, phase=00, zero_state=1, bit_ready=0.
REQ-040 load key=22'h000001, then trigger 1 cycle -> state_q=22'h000002; load 22'h200000, trigger -> state_q=22'h000001.
REQ-041 start, bit_in=1 valid 1 cycle -> state_q=22'h000001, phase=01; trigger in KEY -> no change.
REQ-042 start, 86 valid bits with bit_valid low every other cycle -> phase 01 for 64 accepts, 10 for 22, then 11; init_done high exactly 1 cycle.
REQ-043 start mid-FRAME (bit 10) -> state_q=0, phase=01, counter restarts; load same cycle as start -> load wins, phase=11.
REQ-044 rst_n low during KEY with bit_valid=1 -> next cycle state_q=0, phase=00, no step.

Source files
------------

// File: rtl/a51_pkg.sv
// Shared A5/1 definitions: phase encoding and
// default tap masks for the three LFSRs.
package a51_pkg;

    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_KEY   = 2'b01;
    localparam logic [1:0] PH_FRAME = 2'b10;
    localparam logic [1:0] PH_RUN   = 2'b11;

    localparam logic [18:0] TAP_19 = 19'h72000;
    localparam logic [21:0] TAP_22 = 22'h300000;
    localparam logic [22:0] TAP_23 = 23'h700080;

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lfsr_stage.sv
// One A5/1 shift register with serial key/frame
// initialisation and externally clocked run steps.
module lfsr_stage
    import a51_pkg::*;
#(
    parameter int unsigned         WIDTH      = 22,
    parameter logic [WIDTH-1:0]    TAP_MASK   = TAP_22,
    parameter int unsigned         CLK_BIT    = 10,
    parameter int unsigned         KEY_BITS   = 64,
    parameter int unsigned         FRAME_BITS = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    input  logic             trigger,
    input  logic             load,
    input  logic [WIDTH-1:0] key,
    output logic             out_reg,
    output logic             maj_bit,
    output logic [WIDTH-1:0] state_q,
    output logic [1:0]       phase,
    output logic             init_done,
    output logic             zero_state
);

    localparam int unsigned CW =
        $clog2(max2(KEY_BITS, FRAME_BITS) + 1);

    localparam logic [CW-1:0] KEY_LAST   = CW'(KEY_BITS - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);

    logic [WIDTH-1:0] lfsr_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       phase_q;
    logic             done_q;
    logic             fb;
    logic             accept;
    logic             run_step;

    // Feedback parity and handshake qualifiers
    always_comb begin
        fb        = ^(lfsr_q & TAP_MASK);
        bit_ready = (phase_q == PH_KEY) || (phase_q == PH_FRAME);
        accept    = bit_valid & bit_ready;
        run_step  = trigger & (phase_q == PH_RUN);
    end

    // Register, counter and phase update in priority order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q  <= '0;
            cnt_q   <= '0;
            phase_q <= PH_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                lfsr_q  <= key;
                cnt_q   <= '0;
                phase_q <= PH_RUN;
            end else if (start) begin
                lfsr_q  <= '0;
                cnt_q   <= '0;
                phase_q <= PH_KEY;
            end else if (accept) begin
                lfsr_q <= {lfsr_q[WIDTH-2:0], fb ^ bit_in};
                if (phase_q == PH_KEY) begin
                    if (cnt_q == KEY_LAST) begin
                        cnt_q   <= '0;
                        phase_q <= PH_FRAME;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == FRAME_LAST) begin
                        cnt_q   <= '0;
                        phase_q <= PH_RUN;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end else if (run_step) begin
                lfsr_q <= {lfsr_q[WIDTH-2:0], fb};
            end
        end
    end

    // Direct views of the register, no added latency
    always_comb begin
        out_reg    = lfsr_q[WIDTH-1];
        maj_bit    = lfsr_q[CLK_BIT];
        state_q    = lfsr_q;
        phase      = phase_q;
        init_done  = done_q;
        zero_state = (lfsr_q == '0);
    end

endmodule

// File: tb/tb_lfsr_stage.sv
// Directed self-checking bench for lfsr_stage
// with the default 22-bit configuration.
module tb_lfsr_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        trigger;
    logic        load;
    logic [21:0] key;
    logic        out_reg;
    logic        maj_bit;
    logic [21:0] state_q;
    logic [1:0]  phase;
    logic        init_done;
    logic        zero_state;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt;

    lfsr_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .trigger    (trigger),
        .load       (load),
        .key        (key),
        .out_reg    (out_reg),
        .maj_bit    (maj_bit),
        .state_q    (state_q),
        .phase      (phase),
        .init_done  (init_done),
        .zero_state (zero_state)
    );

    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        trigger   = 1'b0;
        load      = 1'b0;
        key       = '0;
    endtask

    task automatic feed(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state_q), 32'h0);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_zero", 32'(zero_state), 32'h1);
        check("rst_ready", 32'(bit_ready), 32'h0);
        check("rst_out", 32'(out_reg), 32'h0);
        check("rst_maj", 32'(maj_bit), 32'h0);
        check("rst_done", 32'(init_done), 32'h0);
        rst_n = 1'b1;

        // trigger in IDLE is ignored
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("idle_trig", 32'(state_q), 32'h0);

        // parallel load and run steps
        load = 1'b1;
        key  = 22'h000001;
        tick();
        load = 1'b0;
        check("load1_state", 32'(state_q), 32'h000001);
        check("load1_phase", 32'(phase), 32'h3);
        check("load1_zero", 32'(zero_state), 32'h0);
        check("load1_ready", 32'(bit_ready), 32'h0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("trig1", 32'(state_q), 32'h000002);
        tick();
        check("trig_hold", 32'(state_q), 32'h000002);

        load = 1'b1;
        key  = 22'h200000;
        tick();
        load = 1'b0;
        check("load2_out", 32'(out_reg), 32'h1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("trig2", 32'(state_q), 32'h000001);

        load = 1'b1;
        key  = 22'h200400;
        tick();
        load = 1'b0;
        check("maj_hi", 32'(maj_bit), 32'h1);
        check("out_hi", 32'(out_reg), 32'h1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("trig3", 32'(state_q), 32'h000801);

        // serial start, single bit, stall, trigger ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", 32'(state_q), 32'h0);
        check("start_phase", 32'(phase), 32'h1);
        check("start_ready", 32'(bit_ready), 32'h1);
        feed(1'b1);
        check("key1_state", 32'(state_q), 32'h000001);
        check("key1_phase", 32'(phase), 32'h1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("key_trig", 32'(state_q), 32'h000001);
        feed(1'b0);
        feed(1'b1);
        check("key3_state", 32'(state_q), 32'h000005);

        // reset during KEY with a valid bit present
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        rst_n     = 1'b0;
        tick();
        check("rstk_state", 32'(state_q), 32'h0);
        check("rstk_phase", 32'(phase), 32'h0);
        rst_n = 1'b1;
        idle_inputs();
        tick();
        check("rstk_stay", 32'(state_q), 32'h0);

        // full init with stalls between every bit
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 86; i++) begin
            tick();
            if (init_done) done_cnt++;
            feed(1'b0);
            if (init_done) done_cnt++;
            check($sformatf("init_ph%0d", i + 1), 32'(phase),
                  (i + 1 < 64) ? 32'h1 :
                  (i + 1 < 86) ? 32'h2 : 32'h3);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (init_done) done_cnt++;
        end
        check("init_done_cnt", 32'(done_cnt), 32'd1);
        check("init_ready", 32'(bit_ready), 32'h0);
        check("init_state", 32'(state_q), 32'h0);

        // restart in the middle of FRAME
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 74; i++) feed(1'b0);
        check("mid_phase", 32'(phase), 32'h2);
        feed(1'b1);
        check("mid_state", 32'(state_q), 32'h000001);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_state", 32'(state_q), 32'h0);
        check("restart_phase", 32'(phase), 32'h1);
        for (int i = 0; i < 63; i++) feed(1'b0);
        check("restart_63", 32'(phase), 32'h1);
        feed(1'b0);
        check("restart_64", 32'(phase), 32'h2);

        // load beats start in the same cycle
        start = 1'b1;
        load  = 1'b1;
        key   = 22'h0ABCDE;
        tick();
        idle_inputs();
        check("ld_st_phase", 32'(phase), 32'h3);
        check("ld_st_state", 32'(state_q), 32'h0ABCDE);
        tick();
        check("ld_st_done", 32'(init_done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
